// File: rtl/opcode_pkg.sv
// Shared types and widths for the accumulator opcode processor.
// The opcode map is fully decoded: all 16 encodings are defined.
package opcode_pkg;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP  = 4'h0,
        OPC_LOAD = 4'h1,
        OPC_ADD  = 4'h2,
        OPC_SUB  = 4'h3,
        OPC_AND  = 4'h4,
        OPC_OR   = 4'h5,
        OPC_XOR  = 4'h6,
        OPC_NOT  = 4'h7,
        OPC_SHL  = 4'h8,
        OPC_SHR  = 4'h9,
        OPC_ROL  = 4'hA,
        OPC_ROR  = 4'hB,
        OPC_INC  = 4'hC,
        OPC_DEC  = 4'hD,
        OPC_CLR  = 4'hE,
        OPC_SWAP = 4'hF
    } opcode_e;

endpackage

// File: rtl/opcode_alu.sv
// Combinational next-accumulator function.
// All arithmetic wraps modulo 2**DATA_W, and no flags are produced.
module opcode_alu
    import opcode_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] next_acc
);

    always_comb begin
        // NOTE: the default-first assignment guarantees next_acc is driven on every path, so no latch is inferred.
        next_acc = acc;
        case (opcode_e'(opcode))
            OPC_NOP:  next_acc = acc;
            OPC_LOAD: next_acc = data;
            OPC_ADD:  next_acc = acc + data;
            OPC_SUB:  next_acc = acc - data;
            OPC_AND:  next_acc = acc & data;
            OPC_OR:   next_acc = acc | data;
            OPC_XOR:  next_acc = acc ^ data;
            OPC_NOT:  next_acc = ~acc;
            OPC_SHL:  next_acc = {acc[DATA_W-2:0], 1'b0};
            OPC_SHR:  next_acc = {1'b0, acc[DATA_W-1:1]};
            OPC_ROL:  next_acc = {acc[DATA_W-2:0], acc[DATA_W-1]};
            OPC_ROR:  next_acc = {acc[0], acc[DATA_W-1:1]};
            OPC_INC:  next_acc = acc + 1'b1;
            OPC_DEC:  next_acc = acc - 1'b1;
            OPC_CLR:  next_acc = '0;
            OPC_SWAP: next_acc = {acc[DATA_W/2-1:0], acc[DATA_W-1:DATA_W/2]};
            default:  next_acc = acc;
        endcase
    end

endmodule

// File: rtl/opcode_processor.sv
// Accumulator register for the opcode processor; result is the flop output.
// rst_n keeps its historical name but is active-high: 1 clears the accumulator.
module opcode_processor
    import opcode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] next_acc;

    opcode_alu u_alu (
        .opcode   (opcode),
        .acc      (acc),
        .data     (data),
        .next_acc (next_acc)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst_n) begin
            acc <= '0;
        end else begin
            acc <= next_acc;
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_opcode_processor.sv
// Self-checking bench for opcode_processor: directed steps followed by
// randomized opcodes checked against an integer-arithmetic reference model.
module tb_opcode_processor;
    import opcode_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [7:0] data;
    logic [7:0] result;

    int         checks;
    int         errors;
    logic [7:0] prev;

    opcode_processor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .data   (data),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model written from the opcode table using plain integer arithmetic.
    function automatic int model(input int a, input int op, input int d);
        case (op)
            0:  return a;
            1:  return d;
            2:  return (a + d) % 256;
            3:  return (a - d + 256) % 256;
            4:  return a & d;
            5:  return a | d;
            6:  return a ^ d;
            7:  return 255 - a;
            8:  return (a * 2) % 256;
            9:  return a / 2;
            10: return (a * 2) % 256 + a / 128;
            11: return a / 2 + (a % 2) * 128;
            12: return (a + 1) % 256;
            13: return (a + 255) % 256;
            14: return 0;
            default: return (a % 16) * 16 + a / 16;
        endcase
    endfunction

    // Called just after a rising edge: drive, confirm result has not moved yet,
    // then confirm the new value one edge later.
    task automatic step(input string tag, input logic [3:0] op, input logic [7:0] d,
                        input logic [7:0] expected);
        opcode = op;
        data   = d;
        #1;
        check({tag, "_hold"}, result, prev);
        @(posedge clk);
        #1;
        check(tag, result, expected);
        prev = expected;
    endtask

    initial begin
        int         ref_acc;
        int         op;
        int         d;
        int         cycles;
        bit [15:0]  seen;
        bit         inc_wrap_seen;

        checks = 0;
        errors = 0;
        opcode = OPC_NOP;
        data   = 8'h00;
        rst_n  = 1'b0;
        #1 rst_n = 1'b1;

        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_value", result, 8'h00);
        rst_n = 1'b0;
        prev  = 8'h00;

        // Reset asserted mid-stream clears immediately, without a clock edge.
        step("load_5a", OPC_LOAD, 8'h5A, 8'h5A);
        #2 rst_n = 1'b1;
        #1;
        check("async_reset", result, 8'h00);
        opcode = OPC_LOAD;
        data   = 8'h77;
        @(posedge clk);
        #1;
        check("reset_held", result, 8'h00);
        rst_n = 1'b0;
        prev  = 8'h00;
        step("nop_after_reset", OPC_NOP, 8'h33, 8'h00);

        step("load_f0", OPC_LOAD, 8'hF0, 8'hF0);
        step("add_wrap", OPC_ADD, 8'h20, 8'h10);

        step("load_03", OPC_LOAD, 8'h03, 8'h03);
        step("sub_wrap", OPC_SUB, 8'h05, 8'hFE);
        step("clr", OPC_CLR, 8'hAB, 8'h00);
        step("dec_wrap", OPC_DEC, 8'h12, 8'hFF);
        step("inc_wrap", OPC_INC, 8'h00, 8'h00);

        step("load_cc", OPC_LOAD, 8'hCC, 8'hCC);
        step("and", OPC_AND, 8'hAA, 8'h88);
        step("or", OPC_OR, 8'h11, 8'h99);
        step("xor", OPC_XOR, 8'hFF, 8'h66);
        step("not", OPC_NOT, 8'h5C, 8'h99);

        step("load_81a", OPC_LOAD, 8'h81, 8'h81);
        step("shl", OPC_SHL, 8'hFF, 8'h02);
        step("load_81b", OPC_LOAD, 8'h81, 8'h81);
        step("shr", OPC_SHR, 8'hFF, 8'h40);
        step("load_81c", OPC_LOAD, 8'h81, 8'h81);
        step("rol", OPC_ROL, 8'h00, 8'h03);
        step("ror", OPC_ROR, 8'h00, 8'h81);
        step("swap", OPC_SWAP, 8'h00, 8'h18);

        // Random phase: run until every opcode and INC-at-FF have been exercised.
        ref_acc       = 8'h18;
        seen          = '0;
        inc_wrap_seen = 1'b0;
        cycles        = 0;
        while (!(seen == 16'hFFFF && inc_wrap_seen) && cycles < 5000) begin
            op = int'($urandom_range(0, 15));
            d  = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            if (op == 12 && ref_acc == 255) inc_wrap_seen = 1'b1;
            seen[op] = 1'b1;
            opcode   = 4'(op);
            data     = 8'(d);
            @(posedge clk);
            #1;
            ref_acc = model(ref_acc, op, d);
            check("random", result, 8'(ref_acc));
            cycles++;
        end
        check("random_coverage", {7'd0, seen == 16'hFFFF && inc_wrap_seen}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
